ov7670_pixel_packer: RTL and testbench

Capture-side stage between the OV7670 parallel bus and the VRAM write port. It assembles sensor byte pairs (RGB565) into RGB444 pixels and decimates the 640x480 sensor stream 2:1 in each axis to 320x240. It generates the frame-buffer write strobe, address and data, and reports frame completion and geometry errors. It runs entirely in the sensor pixel-clock domain; VRAM port A is clocked from the same domain.

---
 rtl/ov7670_pixel_packer_if.sv | 22 ++
 rtl/ov7670_pixel_packer.sv | 152 +++++++++++++++
 tb/tb_ov7670_pixel_packer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ov7670_pixel_packer_if.sv
// OV7670 capture bus: sensor byte stream in, VRAM write port out.
// master = sensor/VRAM side, slave = the pixel packer.
interface ov7670_pixel_packer_if #(
  parameter int ADDR_W = 17
);
  logic              vsync;
  logic              href;
  logic [7:0]        d;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [11:0]       dout;

  modport master (
    output vsync, href, d,
    input  wr, addr, dout
  );

  modport slave (
    input  vsync, href, d,
    output wr, addr, dout
  );
endinterface

// File: rtl/ov7670_pixel_packer.sv
// OV7670 RGB565 -> RGB444 packer with 2:1 decimation per axis.
// Optional geometry checking: define CAPTURE_ERR_CHECK_EN.
module ov7670_pixel_packer #(
  parameter int H_IN   = 640,
  parameter int V_IN   = 480,
  parameter int ADDR_W = 17
) (
  input  logic                 pclk,
  input  logic                 rst_n,
  input  logic                 enable,
  ov7670_pixel_packer_if.slave bus,
  output logic                 frame_done,
  output logic [7:0]           frame_cnt,
  output logic                 err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SOF,
    ACTIVE
  } state_t;

  localparam logic [10:0]       X_MAX = 11'(H_IN);
  localparam logic [9:0]        Y_MAX = 10'(V_IN);
  localparam logic [ADDR_W-1:0] HALF  = ADDR_W'(H_IN / 2);

  state_t            state;
  logic              vsync_q;
  logic              href_q;
  logic              phase;
  logic [7:0]        hi_byte;
  logic [10:0]       x;
  logic [9:0]        y;
  logic [ADDR_W-1:0] line_base;

  logic [15:0] pix;
  logic [11:0] rgb;
  logic        keep;
  logic        in_rng;
  logic        line_end;
  logic        vs_rise;
  logic        vs_fall;

  // Byte pairing, colour reduction and edge detection.
  always_comb begin
    pix      = {hi_byte, bus.d};
    rgb      = {pix[15:12], pix[10:7], pix[4:1]};
    keep     = ~x[0] & ~y[0];
    in_rng   = (x < X_MAX) && (y < Y_MAX);
    line_end = href_q & ~bus.href;
    vs_rise  = ~vsync_q & bus.vsync;
    vs_fall  = vsync_q & ~bus.vsync;
  end

  // Capture FSM, counters and the registered write port.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vsync_q    <= 1'b0;
      href_q     <= 1'b0;
      phase      <= 1'b0;
      hi_byte    <= '0;
      x          <= '0;
      y          <= '0;
      line_base  <= '0;
      bus.wr     <= 1'b0;
      bus.addr   <= '0;
      bus.dout   <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      vsync_q    <= bus.vsync;
      href_q     <= bus.href;
      bus.wr     <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable) state <= WAIT_SOF;
        end
        WAIT_SOF: begin
          // Disarming before the frame starts returns to idle.
          if (!enable) begin
            state <= IDLE;
          end else if (vs_fall) begin
            state     <= ACTIVE;
            x         <= '0;
            y         <= '0;
            line_base <= '0;
            phase     <= 1'b0;
          end
        end
        ACTIVE: begin
          if (bus.href) begin
            phase <= ~phase;
            if (!phase) begin
              hi_byte <= bus.d;
            end else begin
              x <= x + 11'd1;
              if (keep && in_rng) begin
                bus.wr   <= 1'b1;
                bus.addr <= line_base
                          + ADDR_W'(x[10:1]);
                bus.dout <= rgb;
              end
            end
          end
          if (line_end) begin
            phase <= 1'b0;
            x     <= '0;
            y     <= y + 10'd1;
            if (!y[0]) line_base <= line_base + HALF;
          end
          // Frame end: line-end work above has already been applied.
          if (vs_rise) begin
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 8'd1;
            state      <= enable ? WAIT_SOF : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CAPTURE_ERR_CHECK_EN
  logic [9:0] y_end;
  logic       err_hit;

  // Geometry faults seen this cycle; y_end includes a same-edge line end.
  always_comb begin
    y_end   = line_end ? (y + 10'd1) : y;
    err_hit = 1'b0;
    if (state == ACTIVE) begin
      if (line_end && (phase || (x != X_MAX)))
        err_hit = 1'b1;
      if (vs_rise && (y_end != Y_MAX))
        err_hit = 1'b1;
      if (bus.href && phase && keep && !in_rng)
        err_hit = 1'b1;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else if (err_hit) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ov7670_pixel_packer.sv
// Directed bench for ov7670_pixel_packer on a reduced 16x8 geometry.
// Expected writes are queued as bytes are driven and popped on wr.
module tb_ov7670_pixel_packer;

  localparam int H  = 16;
  localparam int V  = 8;
  localparam int AW = 17;
  localparam int NPIX = (H / 2) * (V / 2);
`ifdef CAPTURE_ERR_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0] a;
    logic [11:0]   d;
  } wr_t;

  logic       pclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       frame_done;
  logic [7:0] frame_cnt;
  logic       err;

  ov7670_pixel_packer_if #(.ADDR_W(AW)) bus ();

  ov7670_pixel_packer #(
    .H_IN(H),
    .V_IN(V),
    .ADDR_W(AW)
  ) dut (
    .pclk(pclk),
    .rst_n(rst_n),
    .enable(enable),
    .bus(bus.slave),
    .frame_done(frame_done),
    .frame_cnt(frame_cnt),
    .err(err)
  );

  always #5 pclk = ~pclk;

  int   errors = 0;
  int   checks = 0;
  wr_t  sb[$];
  wr_t  wlog[$];
  wr_t  mon_e;
  int   nwr = 0;
  int   nfd = 0;
  int   max_a = -1;
  int   mode = 0;
  int   en_line = -1;
  logic en_val = 1'b0;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pix(int x, int y);
    if (mode == 1 && y == 0 && x == 0) return 16'hF800;
    if (mode == 1 && y == 0 && x == 1) return 16'h07E0;
    if (mode == 1 && y == 0 && x == 2) return 16'h001F;
    return 16'((x + H * y) * 331);
  endfunction

  function automatic logic [11:0] to444(logic [15:0] p);
    return {p[15:12], p[10:7], p[4:1]};
  endfunction

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Write monitor and scoreboard.
  always @(negedge pclk) begin
    if (rst_n) begin
      if (frame_done) nfd++;
      if (bus.wr) begin
        nwr++;
        mon_e.a = bus.addr;
        mon_e.d = bus.dout;
        wlog.push_back(mon_e);
        if (int'(bus.addr) > max_a) max_a = int'(bus.addr);
        if (sb.size() == 0) begin
          chk("unexpected_wr", sb.size(), 1);
        end else begin
          mon_e = sb.pop_front();
          chk("wr_addr", bus.addr, mon_e.a);
          chk("wr_dout", bus.dout, mon_e.d);
        end
      end
    end
  end

  task automatic line(int y, int npix, bit odd, bit cap);
    logic [15:0] p;
    for (int i = 0; i < npix; i++) begin
      p = pix(i, y);
      if (y == en_line && i == 2) enable = en_val;
      bus.href = 1'b1;
      bus.d = p[15:8];
      tick();
      bus.d = p[7:0];
      if (cap && i % 2 == 0 && y % 2 == 0 && i < H && y < V)
        sb.push_back('{a: AW'((y / 2) * (H / 2) + i / 2),
                       d: to444(p)});
      tick();
    end
    if (odd) begin
      bus.d = 8'hA5;
      tick();
    end
    bus.href = 1'b0;
    bus.d = 8'h00;
    repeat (3) tick();
  endtask

  task automatic frame(int nl, int sl, bit cap);
    nwr = 0;
    nfd = 0;
    max_a = -1;
    wlog.delete();
    bus.vsync = 1'b0;
    repeat (2) tick();
    for (int y = 0; y < nl; y++)
      line(y, (y == sl) ? H - 1 : H, y == sl, cap);
    bus.vsync = 1'b1;
    repeat (4) tick();
  endtask

  task automatic check_frame(string tag, int ew, int efd,
                             int ecnt, logic eerr);
    chk({tag, "_writes"}, nwr, ew);
    chk({tag, "_done"}, nfd, efd);
    chk({tag, "_cnt"}, frame_cnt, ecnt);
    chk({tag, "_err"}, err, eerr);
    chk({tag, "_sb_left"}, sb.size(), 0);
  endtask

  initial begin
    bus.vsync = 1'b0;
    bus.href = 1'b0;
    bus.d = 8'h00;
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_wr", bus.wr, 0);
    chk("rst_addr", bus.addr, 0);
    chk("rst_dout", bus.dout, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_cnt", frame_cnt, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    tick();

    // Arm, then a partial frame that must not be captured.
    enable = 1'b1;
    repeat (2) tick();
    line(0, H, 0, 0);
    line(1, H, 0, 0);
    bus.vsync = 1'b1;
    repeat (3) tick();
    chk("dummy_writes", nwr, 0);
    chk("dummy_done", nfd, 0);

    mode = 0;
    frame(V, -1, 1);
    check_frame("nominal", NPIX, 1, 1, 1'b0);
    chk("nominal_max_addr", max_a, NPIX - 1);

    mode = 1;
    frame(V, -1, 1);
    check_frame("pack", NPIX, 1, 2, 1'b0);
    if (wlog.size() >= 2) begin
      chk("pack_a0", wlog[0].a, 0);
      chk("pack_d0", wlog[0].d, 12'hF00);
      chk("pack_a1", wlog[1].a, 1);
      chk("pack_d1", wlog[1].d, 12'h00F);
    end else begin
      chk("pack_log", wlog.size(), 2);
    end
    mode = 0;

    // Arm during an active line: nothing until the next SOF.
    enable = 1'b0;
    repeat (2) tick();
    en_line = 1;
    en_val = 1'b1;
    frame(V, -1, 0);
    en_line = -1;
    check_frame("arm_pre", 0, 0, 2, 1'b0);
    frame(V, -1, 1);
    check_frame("arm_post", NPIX, 1, 3, 1'b0);
    if (wlog.size() > 0) chk("arm_first_addr", wlog[0].a, 0);
    else chk("arm_log", wlog.size(), 1);

    // Disarm mid-frame: frame completes, then idle.
    en_line = V / 2;
    en_val = 1'b0;
    frame(V, -1, 1);
    en_line = -1;
    check_frame("disable", NPIX, 1, 4, 1'b0);
    frame(V, -1, 0);
    check_frame("idle", 0, 0, 4, 1'b0);

    // Short line with an odd trailing byte on line 2.
    enable = 1'b1;
    repeat (2) tick();
    frame(V, 2, 1);
    check_frame("short", NPIX, 1, 5, ERR_EN);
    chk("short_max_addr", max_a, NPIX - 1);
    repeat (5) tick();
    chk("err_held", err, ERR_EN);

    // Overlong frame: extra lines must not write.
    frame(V + 4, -1, 1);
    check_frame("overrun", NPIX, 1, 6, ERR_EN);
    chk("overrun_max_addr", max_a, NPIX - 1);

    // Asynchronous reset while a write is on the port.
    bus.vsync = 1'b0;
    repeat (2) tick();
    bus.href = 1'b1;
    bus.d = 8'hFF;
    tick();
    sb.push_back('{a: AW'(0), d: 12'hFFF});
    tick();
    chk("pre_rst_wr", bus.wr, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_wr", bus.wr, 0);
    chk("arst_addr", bus.addr, 0);
    chk("arst_dout", bus.dout, 0);
    chk("arst_cnt", frame_cnt, 0);
    chk("arst_err", err, 0);
    sb.delete();
    bus.href = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
